// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// ALU control values and the registered instruction class.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_R  = 3'd0,
    CL_I  = 3'd1,
    CL_LW = 3'd2,
    CL_SW = 3'd3,
    CL_BR = 3'd4
  } class_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

endpackage

// File: rtl/mcu_if.sv
// Control-unit to datapath/memory signal bundle; master is the control unit.
interface mcu_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       iord;
  logic       mem_req;
  logic       memwrite;
  logic       alusrc;
  logic [3:0] aluctl;
  logic       regwrite;
  logic       mem2reg;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output ir_write, pc_write, pc_src, iord, mem_req, memwrite,
           alusrc, aluctl, regwrite, mem2reg, fault, state
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  ir_write, pc_write, pc_src, iord, mem_req, memwrite,
           alusrc, aluctl, regwrite, mem2reg, fault, state
  );
endinterface

// File: rtl/mcu_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU control,
// branch sense and an illegal-encoding flag.
module mcu_decode
  import mcu_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output class_e     cls,
  output logic [3:0] aluctl,
  output logic       br_ne,
  output logic       illegal
);

  always_comb begin
    cls     = CL_R;
    aluctl  = ALU_ADD;
    br_ne   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CL_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  aluctl = ALU_ADD;
            F3_OR:   aluctl = ALU_OR;
            F3_AND:  aluctl = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          aluctl = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ITYPE: begin
        cls     = CL_I;
        illegal = (funct3 != F3_ADD);
      end
      OP_LOAD: begin
        cls     = CL_LW;
        illegal = (funct3 != F3_LSW);
      end
      OP_STORE: begin
        cls     = CL_SW;
        illegal = (funct3 != F3_LSW);
      end
      OP_BRANCH: begin
        cls    = CL_BR;
        aluctl = ALU_SUB;
        if (funct3 == F3_BEQ) begin
          br_ne = 1'b0;
        end else if (funct3 == F3_BNE && BNE_EN) begin
          br_ne = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM with memory wait-state handshake and a
// stall watchdog that traps into a sticky FAULT state.
//
//   state  | meaning
//   FETCH  | request instruction at PC, load IR and PC+4 on ack
//   DECODE | classify IR, trap on illegal encodings
//   EXEC   | drive ALU; branches resolve here
//   MEM    | data access at ALU result, held until ack
//   WB     | register file write (ALU or memory data)
//   FAULT  | all enables off, left only by reset
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          BNE_EN      = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  mcu_if.master bus
);

  localparam bit          WD_EN = (MEM_TIMEOUT != 0);
  localparam int unsigned WD_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_TC = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  class_e          cls_q, cls_d;
  logic [3:0]      aluctl_q, aluctl_d;
  logic            br_ne_q, br_ne_d;
  logic            fault_q, fault_d;
  logic [WD_W-1:0] wd_q, wd_d;

  class_e     dec_cls;
  logic [3:0] dec_aluctl;
  logic       dec_br_ne;
  logic       dec_illegal;
  logic       stall;
  logic       wd_trip;

  mcu_decode #(.BNE_EN(BNE_EN)) u_decode (
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .cls     (dec_cls),
    .aluctl  (dec_aluctl),
    .br_ne   (dec_br_ne),
    .illegal (dec_illegal)
  );

  // Trip on the last allowed stall cycle so an ack in that cycle still wins.
  assign stall   = (state_q == ST_FETCH || state_q == ST_MEM) && !bus.mem_ready;
  assign wd_trip = WD_EN && stall && (wd_q == WD_TC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      cls_q    <= CL_R;
      aluctl_q <= ALU_AND;
      br_ne_q  <= 1'b0;
      fault_q  <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      aluctl_q <= aluctl_d;
      br_ne_q  <= br_ne_d;
      fault_q  <= fault_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    aluctl_d = aluctl_q;
    br_ne_d  = br_ne_q;
    fault_d  = fault_q;
    wd_d     = '0;
    if (WD_EN && stall) wd_d = wd_q + WD_W'(1);
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready)  state_d = ST_DECODE;
        else if (wd_trip)   state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_FAULT;
        end else begin
          state_d  = ST_EXEC;
          cls_d    = dec_cls;
          aluctl_d = dec_aluctl;
          br_ne_d  = dec_br_ne;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_R, CL_I:   state_d = ST_WB;
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (cls_q == CL_LW) state_d = ST_WB;
          else                state_d = ST_FETCH;
        end else if (wd_trip) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FAULT;
    endcase
    if (state_d == ST_FAULT) fault_d = 1'b1;
  end

  always_comb begin
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src   = 1'b0;
    bus.iord     = 1'b0;
    bus.mem_req  = 1'b0;
    bus.memwrite = 1'b0;
    bus.alusrc   = 1'b0;
    bus.aluctl   = ALU_AND;
    bus.regwrite = 1'b0;
    bus.mem2reg  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      ST_EXEC: begin
        case (cls_q)
          CL_R: bus.aluctl = aluctl_q;
          CL_I, CL_LW, CL_SW: begin
            bus.alusrc = 1'b1;
            bus.aluctl = ALU_ADD;
          end
          default: begin
            bus.aluctl   = ALU_SUB;
            bus.pc_write = br_ne_q ? !bus.zero : bus.zero;
            bus.pc_src   = br_ne_q ? !bus.zero : bus.zero;
          end
        endcase
      end
      ST_MEM: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.memwrite = (cls_q == CL_SW);
      end
      ST_WB: begin
        bus.regwrite = 1'b1;
        bus.mem2reg  = (cls_q == CL_LW);
      end
      default: ;
    endcase
    // A cycle spent in reset must never commit architectural state.
    if (!rst_n) begin
      bus.ir_write = 1'b0;
      bus.pc_write = 1'b0;
      bus.memwrite = 1'b0;
      bus.regwrite = 1'b0;
    end
  end

  assign bus.fault = fault_q;
  assign bus.state = state_q;

endmodule
